// File: rtl/alu_64_pkg.sv
// Shared constants for the alu_64 block: datapath width and opcode encodings.
// Optional carry output is enabled by defining ALU_CARRY_EN.
package alu_64_pkg;

    localparam int WIDTH = 64;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

endpackage

// File: rtl/alu_adder_64.sv
// Ripple-free adder with carry-in, exposing the carry into and out of the MSB
// so the caller can derive signed overflow and unsigned carry/borrow.
module alu_adder_64
    import alu_64_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [W-2:0] low;
    logic         top;

    // Split at the MSB so the carry into bit W-1 is available directly.
    assign {cmsb, low} = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + {{(W-1){1'b0}}, cin};
    assign {cout, top} = {1'b0, x[W-1]} + {1'b0, y[W-1]} + {1'b0, cmsb};
    assign sum = {top, low};

endmodule

// File: rtl/alu_64.sv
// One-cycle registered ALU: add, sub, and, xor with overflow and zero flags.
// Defining ALU_CARRY_EN adds a registered carry/borrow output.
module alu_64
    import alu_64_pkg::*;
#(
    parameter int WIDTH = alu_64_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
`ifdef ALU_CARRY_EN
    ,
    output logic             carry
`endif
);

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             cmsb;
    logic [WIDTH-1:0] r;
    logic             ov;

    assign is_sub = (opcode == OP_SUB);
    assign b_eff  = is_sub ? ~b : b;

    alu_adder_64 #(
        .W(WIDTH)
    ) u_adder (
        .x   (a),
        .y   (b_eff),
        .cin (is_sub),
        .sum (sum),
        .cout(cout),
        .cmsb(cmsb)
    );

    // Signed overflow is the MSB carry-in differing from the carry-out.
    always_comb begin
        r  = '0;
        ov = 1'b0;
        unique case (opcode)
            OP_ADD: begin
                r  = sum;
                ov = cmsb ^ cout;
            end
            OP_SUB: begin
                r  = sum;
                ov = cmsb ^ cout;
            end
            OP_AND: r = a & b;
            OP_XOR: r = a ^ b;
        endcase
    end

`ifdef ALU_CARRY_EN
    logic cy;

    // For sub the adder carry-out is the inverse of the unsigned borrow.
    always_comb begin
        cy = 1'b0;
        unique case (opcode)
            OP_ADD:  cy = cout;
            OP_SUB:  cy = ~cout;
            default: cy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry <= 1'b0;
        end else if (in_valid) begin
            carry <= cy;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res       <= '0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                res      <= r;
                overflow <= ov;
                zero     <= (r == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_64.sv
// Directed self-checking bench for alu_64 with hand-computed expectations.
// Carry checks are included when ALU_CARRY_EN is defined.
module tb_alu_64;
    import alu_64_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  opcode;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        overflow;
    logic        zero;
    logic        out_valid;
`ifdef ALU_CARRY_EN
    logic        carry;
`endif

    int total;
    int bad;

    alu_64 #(
        .WIDTH(64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .opcode   (opcode),
        .a        (a),
        .b        (b),
        .res      (res),
        .overflow (overflow),
        .zero     (zero),
        .out_valid(out_valid)
`ifdef ALU_CARRY_EN
        ,
        .carry    (carry)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [63:0] x,
                         input logic [63:0] y);
        opcode   = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [63:0] r,
                              input logic ov, input logic z);
        chk({tag, ".res"}, res, r);
        chk({tag, ".ov"}, 64'(overflow), 64'(ov));
        chk({tag, ".zero"}, 64'(zero), 64'(z));
        chk({tag, ".vld"}, 64'(out_valid), 64'd1);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        opcode   = OP_ADD;
        a        = 64'd0;
        b        = 64'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.res", res, 64'd0);
        chk("rst.ov", 64'(overflow), 64'd0);
        chk("rst.zero", 64'(zero), 64'd0);
        chk("rst.vld", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(OP_ADD, 64'd5, 64'd7);
        expect_out("add5_7", 64'd12, 1'b0, 1'b0);
`ifdef ALU_CARRY_EN
        chk("add5_7.cy", 64'(carry), 64'd0);
`endif

        issue(OP_SUB, 64'd10, 64'd10);
        expect_out("sub10_10", 64'd0, 1'b0, 1'b1);
`ifdef ALU_CARRY_EN
        chk("sub10_10.cy", 64'(carry), 64'd0);
`endif

        issue(OP_SUB, 64'h8000_0000_0000_0000, 64'd1);
        expect_out("submin_1", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);

        issue(OP_AND, 64'hF0F0, 64'hFF00);
        expect_out("and", 64'hF000, 1'b0, 1'b0);

        issue(OP_XOR, 64'hF0F0, 64'hFF00);
        expect_out("xor", 64'h0FF0, 1'b0, 1'b0);

        issue(OP_XOR, 64'h1234, 64'h1234);
        expect_out("xorsame", 64'd0, 1'b0, 1'b1);

        issue(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        expect_out("addmax_1", 64'h8000_0000_0000_0000, 1'b1, 1'b0);

        issue(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_out("addm1_m1", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
`ifdef ALU_CARRY_EN
        chk("addm1_m1.cy", 64'(carry), 64'd1);
`endif

        issue(OP_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        expect_out("addmin_min", 64'd0, 1'b1, 1'b1);

        issue(OP_ADD, 64'd1, 64'd2);
        expect_out("b2b.add", 64'd3, 1'b0, 1'b0);
        issue(OP_SUB, 64'd1, 64'd2);
        expect_out("b2b.sub", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
`ifdef ALU_CARRY_EN
        chk("b2b.sub.cy", 64'(carry), 64'd1);
`endif
        issue(OP_XOR, 64'd3, 64'd3);
        expect_out("b2b.xor", 64'd0, 1'b0, 1'b1);

        in_valid = 1'b0;
        opcode   = OP_ADD;
        a        = 64'd9;
        b        = 64'd9;
        @(posedge clk);
        #1;
        chk("idle.vld", 64'(out_valid), 64'd0);
        chk("idle.res", res, 64'd0);
        chk("idle.zero", 64'(zero), 64'd1);
        @(posedge clk);
        #1;
        chk("idle2.res", res, 64'd0);

        issue(OP_ADD, 64'd5, 64'd7);
        expect_out("pre_rst", 64'd12, 1'b0, 1'b0);
        opcode = OP_SUB;
        a      = 64'd3;
        b      = 64'd4;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst.res", res, 64'd0);
        chk("mid_rst.ov", 64'(overflow), 64'd0);
        chk("mid_rst.zero", 64'(zero), 64'd0);
        chk("mid_rst.vld", 64'(out_valid), 64'd0);
`ifdef ALU_CARRY_EN
        chk("mid_rst.cy", 64'(carry), 64'd0);
`endif
        @(posedge clk);
        #1;
        chk("rst_edge.vld", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(OP_SUB, 64'd3, 64'd4);
        expect_out("post_rst", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
